// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin writeback arbiter for the integer register file
// write port, with a pending-write scoreboard for decoder operand stalls.
// Optional feature macro: RF_WB_FORWARD_EN. When it is defined, the pending bit
// clears at the acceptance edge and the write port data is forwarded to the
// decoder's source queries.
module rf_wb_scheduler #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  input  logic                    alloc_valid,
  input  logic [4:0]              alloc_addr,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rf_we,
  output logic [4:0]              rf_addr,
  output logic [XLEN-1:0]         rf_din
`ifdef RF_WB_FORWARD_EN
  ,
  output logic                    rs1_fwd_valid,
  output logic                    rs2_fwd_valid,
  output logic [XLEN-1:0]         rs1_fwd_data,
  output logic [XLEN-1:0]         rs2_fwd_data
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREG  = 32;

  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               found;
  logic               transfer;
  logic [4:0]         sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic [NREG-1:0]    pending;
  logic [NREG-1:0]    set_vec;
  logic [NREG-1:0]    clr_vec;
  logic [NREG-1:0]    pending_next;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int unsigned k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = 32'(last_grant) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_valid[IDX_W'(k)]) begin
        grant[IDX_W'(k)] = 1'b1;
        grant_idx        = IDX_W'(k);
        found            = 1'b1;
      end
    end
  end

  assign req_ready = reset ? '0 : grant;
  assign transfer  = |req_ready;

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        sel_addr = req_addr[5*r +: 5];
        sel_data = req_data[XLEN*r +: XLEN];
      end
    end
  end

  // Scoreboard update: a new producer's set overrides the old producer's clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (alloc_valid && (alloc_addr != 5'd0)) set_vec = NREG'(1) << alloc_addr;
`ifdef RF_WB_FORWARD_EN
    if (transfer && (sel_addr != 5'd0)) clr_vec = NREG'(1) << sel_addr;
`else
    if (rf_we) clr_vec = NREG'(1) << rf_addr;
`endif
    pending_next = (pending & ~clr_vec) | set_vec;
  end

  // Write-port registers, round-robin pointer and pending bitmap.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_din     <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      pending    <= '0;
    end else begin
      rf_we   <= transfer && (sel_addr != 5'd0);
      pending <= pending_next;
      if (transfer) begin
        rf_addr    <= sel_addr;
        rf_din     <= sel_data;
        last_grant <= grant_idx;
      end
    end
  end

  assign rs1_busy = (rs1_addr != 5'd0) && pending[rs1_addr];
  assign rs2_busy = (rs2_addr != 5'd0) && pending[rs2_addr];

`ifdef RF_WB_FORWARD_EN
  assign rs1_fwd_valid = rf_we && (rf_addr == rs1_addr) && (rs1_addr != 5'd0);
  assign rs2_fwd_valid = rf_we && (rf_addr == rs2_addr) && (rs2_addr != 5'd0);
  assign rs1_fwd_data  = rf_din;
  assign rs2_fwd_data  = rf_din;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with a write-port scoreboard.
module tb_rf_wb_scheduler;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned XLEN    = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [5*NUM_REQ-1:0]    req_addr;
  logic [XLEN*NUM_REQ-1:0] req_data;
  logic                    alloc_valid;
  logic [4:0]              alloc_addr;
  logic [4:0]              rs1_addr, rs2_addr;
  logic                    rs1_busy, rs2_busy;
  logic                    rf_we;
  logic [4:0]              rf_addr;
  logic [XLEN-1:0]         rf_din;
`ifdef RF_WB_FORWARD_EN
  logic                    rs1_fwd_valid, rs2_fwd_valid;
  logic [XLEN-1:0]         rs1_fwd_data, rs2_fwd_data;
`endif

  rf_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din)
`ifdef RF_WB_FORWARD_EN
    ,
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [4:0] a, input logic [31:0] d);
    req_addr[5*r +: 5]       = a;
    req_data[XLEN*r +: XLEN] = d;
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the next expected writeback.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_unexpected: got write x%0d=0x%08h expected no write", rf_addr, rf_din);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_addr", 32'(rf_addr), 32'(e.addr));
          check("wb_data", rf_din, e.data);
        end
      end
    end
  end

  logic [2:0] exp_g [4];
  int         exp_i [4];
  logic [4:0] t2_addr [3];
  logic [31:0] t2_data [3];

  initial begin
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_i   = '{0, 1, 2, 0};
    t2_addr = '{5'd1, 5'd2, 5'd3};
    t2_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    reset = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;

    // Reset state, and no grants while reset is high
    step();
    mid();
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_addr", 32'(rf_addr), 32'd0);
    check("reset_rf_din", rf_din, 32'd0);
    step();
    reset = 1'b0; req_valid = '0;
    mid();
    check("idle_ready", 32'(req_ready), 32'd0);
    check("x0_busy_idle", 32'(rs1_busy), 32'd0);

    // Single request from requester 1
    step();
    req_valid = 3'b010; set_req(1, 5'd5, 32'hDEAD_BEEF);
    mid();
    check("t1_ready", 32'(req_ready), 32'b010);
    expect_wb(5'd5, 32'hDEAD_BEEF);
    step();
    req_valid = '0;
    mid();
    check("t1_we", 32'(rf_we), 32'd1);
    check("t1_addr", 32'(rf_addr), 32'd5);
    check("t1_din", rf_din, 32'hDEAD_BEEF);
    step();
    mid();
    check("t1_we_drop", 32'(rf_we), 32'd0);

    // Fresh reset so the round-robin pointer starts at requester 0
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // All three requesters valid for four cycles
    for (int r = 0; r < 3; r++) set_req(r, t2_addr[r], t2_data[r]);
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("rr_grant", 32'(req_ready), 32'(exp_g[i]));
      expect_wb(t2_addr[exp_i[i]], t2_data[exp_i[i]]);
      step();
    end
    req_valid = '0;

    // Requester 2 writes x0: accepted, no write, no busy
    req_valid = 3'b100; set_req(2, 5'd0, 32'h0000_1234); rs1_addr = 5'd0;
    mid();
    check("x0_ready", 32'(req_ready), 32'b100);
    check("x0_busy", 32'(rs1_busy), 32'd0);
    step();
    req_valid = '0;
    mid();
    check("x0_no_we", 32'(rf_we), 32'd0);
    check("x0_busy_after", 32'(rs1_busy), 32'd0);

    // Allocate x7, then write it back from requester 0
    step();
    alloc_valid = 1'b1; alloc_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd7;
    mid();
    check("alloc_same_cycle", 32'(rs1_busy), 32'd0);
    step();
    alloc_valid = 1'b0;
    mid();
    check("alloc_busy", 32'(rs1_busy), 32'd1);
    step();
    req_valid = 3'b001; set_req(0, 5'd7, 32'hCAFE_0007);
    mid();
    check("x7_busy_accept", 32'(rs1_busy), 32'd1);
    check("x7_ready", 32'(req_ready), 32'b001);
    expect_wb(5'd7, 32'hCAFE_0007);
    step();
    req_valid = '0;
    mid();
`ifdef RF_WB_FORWARD_EN
    check("x7_busy_we", 32'(rs1_busy), 32'd0);
    check("x7_busy2_we", 32'(rs2_busy), 32'd0);
    check("x7_fwd1_valid", 32'(rs1_fwd_valid), 32'd1);
    check("x7_fwd2_valid", 32'(rs2_fwd_valid), 32'd1);
    check("x7_fwd1_data", rs1_fwd_data, 32'hCAFE_0007);
    check("x7_fwd2_data", rs2_fwd_data, 32'hCAFE_0007);
`else
    check("x7_busy_we", 32'(rs1_busy), 32'd1);
    check("x7_busy2_we", 32'(rs2_busy), 32'd1);
`endif
    step();
    mid();
    check("x7_busy_after", 32'(rs1_busy), 32'd0);
    check("x7_busy2_after", 32'(rs2_busy), 32'd0);
`ifdef RF_WB_FORWARD_EN
    check("x7_fwd_after", 32'(rs1_fwd_valid), 32'd0);
`endif

    // Same-cycle set and clear of x9: set wins
    step();
    req_valid = 3'b010; set_req(1, 5'd9, 32'h0000_0099); rs1_addr = 5'd9;
`ifdef RF_WB_FORWARD_EN
    alloc_valid = 1'b1; alloc_addr = 5'd9;
`endif
    mid();
    check("x9_ready", 32'(req_ready), 32'b010);
    expect_wb(5'd9, 32'h0000_0099);
    step();
    req_valid = '0;
`ifdef RF_WB_FORWARD_EN
    alloc_valid = 1'b0;
`else
    alloc_valid = 1'b1; alloc_addr = 5'd9;
`endif
    mid();
    step();
    alloc_valid = 1'b0;
    mid();
    check("x9_set_wins", 32'(rs1_busy), 32'd1);

    // Reset while a write is in flight
    step();
    req_valid = 3'b010; set_req(1, 5'd12, 32'hAAAA_000C);
    mid();
    check("rst_req_ready", 32'(req_ready), 32'b010);
    expect_wb(5'd12, 32'hAAAA_000C);
    step();
    reset = 1'b1;
    mid();
    check("rst_ready_low", 32'(req_ready), 32'd0);
    check("rst_inflight_we", 32'(rf_we), 32'd1);
    step();
    reset = 1'b0; req_valid = '0; rs1_addr = 5'd9; rs2_addr = 5'd12;
    mid();
    check("rst_we_dropped", 32'(rf_we), 32'd0);
    check("rst_pending_x9", 32'(rs1_busy), 32'd0);
    check("rst_pending_x12", 32'(rs2_busy), 32'd0);

    // Pointer restarts at requester 0 after reset
    step();
    req_valid = 3'b011; set_req(0, 5'd3, 32'h0000_0030);
    mid();
    check("rst_rr_grant", 32'(req_ready), 32'b001);
    expect_wb(5'd3, 32'h0000_0030);
    step();
    req_valid = '0;
    mid();
    step();
    mid();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
